sreg_serializer: RTL
====================

# sreg_serializer

- Upstream feeder for the 4-bit serial-in shift register.
- Accepts parallel words on a valid/ready handshake and emits them one bit per clock on a serial line. That line drives the register's serial input (`sinp`).
- `sout_valid` qualifies each emitted bit. `frame_done` marks the last bit of each word, so downstream logic knows when a full word has been shifted in.

## Interface
- `WIDTH`, default 4: data bits per word (≥2).
- `MSB_FIRST`, default 1: 1 = bit WIDTH-1 first; 0 = bit 0 first.
- `GAP`, default 1: idle cycles inserted after each word (0..15).
- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `din` input WIDTH: parallel word.
- `din_valid` input 1: `din` is presentable.
- `din_ready` output 1: block can accept a word this cycle.
- `sout` output 1: serial data bit; connects to the shift register's `sinp`.
- `sout_valid` output 1: `sout` carries a frame bit this cycle.
- `frame_done` output 1: one-cycle pulse coincident with the last bit of the frame.
- `busy` output 1: high in any state other than IDLE.

## Operation
- **States:** IDLE, SHIFT, PARITY (only with `SREG_SER_PARITY_EN`), GAP.
- **IDLE**
  - `din_ready`=1.
  - On an edge with `din_valid`&`din_ready`: capture `din` into the internal shift word, set the bit counter to WIDTH-1, go to SHIFT.
- **SHIFT**
  - `sout_valid`=1.
  - `sout` = current head bit: MSB of the word if `MSB_FIRST`, else LSB.
  - Each edge: shift the word toward the head and decrement the counter.
  - When the counter reaches 0, the next state is PARITY if enabled. Otherwise it is GAP (GAP>0) or IDLE (GAP=0).
- **PARITY:** one cycle. `sout` = XOR of all captured data bits (even parity), `sout_valid`=1.
- **GAP**
  - `sout`=0, `sout_valid`=0, `din_ready`=0.
  - Stays for exactly GAP cycles, then goes to IDLE.
- **Outside IDLE:** `din_ready`=0, and `din_valid` is ignored (no capture, no queuing).
- **Idle output:** `sout`=0 whenever `sout_valid`=0.
- **Counter width:** the bit counter is $clog2(WIDTH) bits; the gap counter is 4 bits. No wrap beyond the loaded value.
- **`frame_done`:** asserted in the final bit cycle of the frame. That is the last SHIFT cycle without parity, or the PARITY cycle with parity.

## Timing
- **Reset:** all outputs are registered or decoded from registered state. After a reset edge:
  - state = IDLE
  - `sout`=0, `sout_valid`=0, `frame_done`=0, `busy`=0
  - `din_ready`=1
- **Reset mid-frame:** aborts immediately at that edge. No `frame_done`, the partial word is discarded, and the next cycle is IDLE.
- **Reset with `din_valid`:** reset wins; no capture.
- **Latency:** word accepted at edge k → first bit valid in cycle k+1 → last data bit in cycle k+WIDTH → parity (if enabled) in cycle k+WIDTH+1.
- **Throughput:** WIDTH + P + GAP + 1 cycles per word, where P = 1 with parity and 0 without. The +1 is the IDLE accept cycle.
- **Sampling:** bits change only on clock edges. The consuming register samples `sout` on the following edge.

## Configuration
- **`SREG_SER_PARITY_EN` defined:**
  - the PARITY state exists;
  - frames are WIDTH+1 bits, with the even-parity bit last;
  - `frame_done` moves to the parity cycle.
- **`SREG_SER_PARITY_EN` undefined:**
  - no PARITY state and no parity logic;
  - frames are exactly WIDTH bits.

## Test plan
- **MSB-first word:** WIDTH=4, MSB_FIRST=1, GAP=1, no parity; `din`=4'b1011 accepted at edge 0.
  - `sout`=1,0,1,1 in cycles 1–4 with `sout_valid`=1.
  - `frame_done` in cycle 4.
  - Cycle 5 GAP (`sout_valid`=0), cycle 6 `din_ready`=1.
- **LSB-first word:** MSB_FIRST=0, `din`=4'b1011 → `sout`=1,1,0,1 in cycles 1–4.
- **Parity:** `SREG_SER_PARITY_EN`, `din`=4'b1011 → data bits as above, then `sout`=1 in cycle 5 with `frame_done`. For `din`=4'b0110 the parity bit is 0.
- **Held valid:** `din_valid` held high with `din`=4'b1100 then 4'b0011 (switched in cycle 2), GAP=2.
  - The second word is not captured until the IDLE cycle 7.
  - Its first bit appears in cycle 8.
- **Reset mid-frame:** reset asserted in cycle 2 of a frame.
  - Next cycle: `sout_valid`=0, `busy`=0, `din_ready`=1.
  - No `frame_done`.
  - A new word 4'b1111 then serializes cleanly.
- **GAP=0 back-to-back:** stream 4'b1000, 4'b0001 with `din_valid` held.
  - Exactly 5 cycles per word.
  - `sout` sequence 1,0,0,0,(idle 0),0,0,0,1.

Source files
------------

// File: rtl/sreg_serializer.sv
// Parallel-word to serial-bit feeder for a serial-in shift register (valid/ready in, bit stream out).
// Optional even-parity trailer bit: define SREG_SER_PARITY_EN.
module sreg_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned GAP_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);

`ifdef SREG_SER_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_GAP    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd3
  } state_t;
`endif

  // State after the final frame bit: skip GAP entirely when no idle cycles are requested.
  localparam state_t S_AFTER = (GAP == 0) ? S_IDLE : S_GAP;

  state_t           r_state;
  logic [WIDTH-1:0] r_word;
  logic [CNT_W-1:0] r_cnt;
  logic [GAP_W-1:0] r_gap;
  logic             r_sout;
  logic             r_sout_valid;
  logic             r_frame_done;
  logic             r_busy;
  logic             r_din_ready;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_word_nxt;
  logic [WIDTH-1:0] w_word_shifted;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [GAP_W-1:0] w_gap_nxt;
  logic             w_sout_nxt;
  logic             w_sout_valid_nxt;
  logic             w_frame_done_nxt;
  logic             w_busy_nxt;
  logic             w_din_ready_nxt;

`ifdef SREG_SER_PARITY_EN
  logic r_par;
  logic w_par_nxt;
`endif

  assign w_word_shifted = MSB_FIRST ? {r_word[WIDTH-2:0], 1'b0}
                                    : {1'b0, r_word[WIDTH-1:1]};

  // Next-state, datapath and next-output decode; outputs are registered from these.
  always_comb begin
    w_state_nxt      = r_state;
    w_word_nxt       = r_word;
    w_cnt_nxt        = r_cnt;
    w_gap_nxt        = r_gap;
    w_sout_nxt       = 1'b0;
    w_sout_valid_nxt = 1'b0;
    w_frame_done_nxt = 1'b0;
    w_busy_nxt       = 1'b0;
    w_din_ready_nxt  = 1'b0;
`ifdef SREG_SER_PARITY_EN
    w_par_nxt        = r_par;
`endif

    case (r_state)
      S_IDLE: begin
        if (din_valid) begin
          w_word_nxt  = din;
          w_cnt_nxt   = CNT_LAST;
          w_state_nxt = S_SHIFT;
`ifdef SREG_SER_PARITY_EN
          w_par_nxt   = ^din;
`endif
        end
      end
      S_SHIFT: begin
        w_word_nxt = w_word_shifted;
        if (r_cnt == '0) begin
          w_cnt_nxt   = '0;
`ifdef SREG_SER_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_AFTER;
          w_gap_nxt   = GAP_LOAD;
`endif
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
`ifdef SREG_SER_PARITY_EN
      S_PARITY: begin
        w_state_nxt = S_AFTER;
        w_gap_nxt   = GAP_LOAD;
      end
`endif
      S_GAP: begin
        if (r_gap <= GAP_W'(1)) begin
          w_gap_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = r_gap - GAP_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_state_nxt == S_SHIFT) begin
      w_sout_valid_nxt = 1'b1;
      w_sout_nxt       = MSB_FIRST ? w_word_nxt[WIDTH-1] : w_word_nxt[0];
`ifndef SREG_SER_PARITY_EN
      w_frame_done_nxt = (w_cnt_nxt == '0);
`endif
    end
`ifdef SREG_SER_PARITY_EN
    if (w_state_nxt == S_PARITY) begin
      w_sout_valid_nxt = 1'b1;
      w_sout_nxt       = w_par_nxt;
      w_frame_done_nxt = 1'b1;
    end
`endif
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_din_ready_nxt = (w_state_nxt == S_IDLE);
  end

  // State, datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_word       <= '0;
      r_cnt        <= '0;
      r_gap        <= '0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_din_ready  <= 1'b1;
`ifdef SREG_SER_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_word       <= w_word_nxt;
      r_cnt        <= w_cnt_nxt;
      r_gap        <= w_gap_nxt;
      r_sout       <= w_sout_nxt;
      r_sout_valid <= w_sout_valid_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_busy       <= w_busy_nxt;
      r_din_ready  <= w_din_ready_nxt;
`ifdef SREG_SER_PARITY_EN
      r_par        <= w_par_nxt;
`endif
    end
  end

  assign din_ready  = r_din_ready;
  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

endmodule
